// File: rtl/piso_serializer.sv
// Purpose : parallel-in serial-out transmitter; shifts a SIZE-bit word out on SO, one bit per shift_en cycle.
// Latency : word accepted at edge N drives its first bit on SO from cycle N+1; SIZE enabled cycles per word.
// Backpr. : load_ready is high only in IDLE or in the last-bit cycle; shift_en low stalls SO, frame and the counter.
// Ports   : clk/rstn (async active-low) | data_in, load_valid, load_ready : word handshake
//           shift_en : bit-rate strobe | SO, frame, done : registered serial data, frame qualifier, end-of-word pulse
module piso_serializer #(
  parameter int SIZE      = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [SIZE-1:0] data_in,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            shift_en,
  output logic            SO,
  output logic            frame,
  output logic            done
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);
  // Bit position that drives SO, and the one that reaches it after a shift.
  localparam int OUT_IDX = (MSB_FIRST != 0) ? SIZE - 1 : 0;
  localparam int NXT_IDX = (MSB_FIRST != 0) ? SIZE - 2 : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_shreg;
  logic [CW-1:0]   r_cnt;
  logic            r_so;
  logic            r_frame;
  logic            r_done;

  logic            w_last;
  logic            w_load_ready;
  logic            w_accept;
  logic [SIZE-1:0] w_shifted;

  // The last enabled bit frees the shifter, so a new word can be taken in
  // that same cycle for zero-gap back-to-back frames.
  assign w_last       = (r_state == ST_SHIFT) && shift_en && (r_cnt == LAST_CNT);
  assign w_load_ready = (r_state == ST_IDLE) || w_last;
  assign w_accept     = load_valid && w_load_ready;
  assign w_shifted    = (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_so    <= 1'b0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shreg <= data_in;
            r_cnt   <= '0;
            r_so    <= data_in[OUT_IDX];
            r_frame <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (w_last) begin
              r_done <= 1'b1;
              if (w_accept) begin
                r_shreg <= data_in;
                r_cnt   <= '0;
                r_so    <= data_in[OUT_IDX];
              end else begin
                r_shreg <= '0;
                r_cnt   <= '0;
                r_so    <= 1'b0;
                r_frame <= 1'b0;
                r_state <= ST_IDLE;
              end
            end else begin
              // SO is registered, so it takes the bit that becomes the
              // output end after this shift.
              r_shreg <= w_shifted;
              r_so    <= r_shreg[NXT_IDX];
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = w_load_ready;
  assign SO         = r_so;
  assign frame      = r_frame;
  assign done       = r_done;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Loads a SIZE-bit word through a valid/ready handshake and shifts it out one bit per enabled cycle on SO.
- Acts as the source end of the serial link that the shift-register chain consumes.
- Provides a frame qualifier and an end-of-word pulse for downstream alignment.
- Supports back-to-back words with no idle gap.

Parameters:
- SIZE, 4, word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit SIZE-1 goes out first; 0 = bit 0 goes out first.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- data_in  input  SIZE  parallel word to transmit. Sampled only on handshake.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word this cycle. Combinational.
- shift_en  input  1  bit-rate strobe. Advances to the next bit when high.
- SO  output  1  serial data out. Registered.
- frame  output  1  high while SO carries a valid bit. Registered.
- done  output  1  one-cycle pulse when the last bit of a word is consumed. Registered.

Behaviour:
- Reset (rstn low, asynchronous): state = IDLE, shift register = 0, bit counter = 0, SO = 0, frame = 0, done = 0. Takes effect immediately, including mid-word. The partial word is discarded and not resumed.
- Handshake: a word is accepted on a rising edge where load_valid && load_ready. data_in is captured at that edge.
- load_valid may stay high across words. Holding data_in stable is the source's job.
- FSM states: IDLE and SHIFT.
- IDLE:
  - load_ready = 1, frame = 0, SO = 0.
  - On accept: capture the word, counter = 0, go to SHIFT.
- SHIFT:
  - frame = 1.
  - SO = current bit: the captured MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of the shift register.
  - The bit is held on SO until a cycle with shift_en = 1. On that edge the register shifts toward the output end and the counter increments.
- Last-bit handling (counter == SIZE-1 and shift_en = 1):
  - done = 1 on the next cycle, for exactly one cycle.
  - load_ready = 1 combinationally in this cycle only; otherwise load_ready = 0 throughout SHIFT.
  - If accepted in the same cycle: load the new word, counter = 0, stay in SHIFT. frame stays 1 and the new word's first bit appears on the next cycle (zero-gap).
  - If not accepted: go to IDLE. frame = 0 and SO = 0 on the next cycle.
- Latency:
  - Accept at edge N puts bit 0 of the frame on SO for cycle N+1.
  - With shift_en tied high, a word occupies exactly SIZE cycles of frame.
- shift_en is ignored in IDLE.
- shift_en low during SHIFT stalls: SO, frame and the counter all hold.
- load_valid during SHIFT (other than the last-bit cycle) is not accepted and has no effect.
- Counter width is $clog2(SIZE). No wrap beyond SIZE-1 is ever observable.
- done is never asserted in IDLE except in the single cycle following the last-bit transition.
- No X on any output after reset.

Test Plan:
- Reset, then hold rstn high for 3 cycles with no load_valid -> SO = 0, frame = 0, done = 0, load_ready = 1 throughout.
- SIZE=4, MSB_FIRST=1, shift_en=1, load data_in = 4'b1011 once -> SO = 1,0,1,1 on cycles N+1..N+4 with frame = 1. done = 1 on cycle N+5, and frame = 0 and load_ready = 1 on that cycle.
- MSB_FIRST=0, same word 4'b1011 -> SO = 1,1,0,1.
- Back-to-back: load_valid held high with 4'b1100 then 4'b0011, shift_en = 1 -> SO = 1,1,0,0,0,0,1,1. frame stays 1 for 8 continuous cycles. done pulses after bit 4 and after bit 8.
- Stall: shift_en toggles 1,0,0,1,... while sending 4'b1001 -> each bit is held while shift_en = 0. Serial order stays 1,0,0,1. done asserts only after the 4th enabled cycle.
- Mid-word reset: assert rstn low after 2 bits of 4'b1111 -> SO, frame and done go 0 immediately. After release, load_ready = 1 and a new word 4'b0101 transmits correctly from its first bit.
